// File: rtl/mul_arb_pkg.sv
// Shared constants for the two-requester multiplier arbiter: FSM state
// encoding and requester ids.
package mul_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier. A start pulse latches the
// operands and clears the accumulator and bit counter; each following cycle
// processes one multiplier bit, so a product always takes Width cycles.
// 'done' is high during the final iteration and 'product' then carries the
// accumulator value including that last step, so the owner can capture the
// finished product on the same edge that completes it.
module seq_multiplier #(
  parameter int Width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [Width-1:0]   a,
  input  logic [Width-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*Width-1:0] product
);

  localparam int CntW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [Width-1:0]   a_q;
  logic [Width-1:0]   b_q;
  logic [2*Width-1:0] acc_q;
  logic [2*Width-1:0] acc_next;
  logic [CntW-1:0]    cnt_q;
  logic               run_q;

  // Partial-product add for the bit currently selected by the counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    acc_next = acc_q;
    if (b_q[cnt_q]) begin
      acc_next = acc_q + ({{Width{1'b0}}, a_q} << cnt_q);
    end
  end

  // Operand latches, accumulator and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand latches are plain registers, not a memory array,
      // so they take the reset as well; an abort leaves no stale operands.
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        run_q <= 1'b0;
      end
    end
  end

  assign busy    = run_q;
  assign done    = run_q && (cnt_q == LastCnt);
  assign product = acc_next;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between two
// requesters. IDLE accepts the winning request and starts the multiplier,
// CALC waits for the final iteration, DONE publishes the tagged product for
// one cycle. Ties go to the requester that did not win last.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [Width-1:0]   a0,
  input  logic [Width-1:0]   b0,
  input  logic               req1,
  input  logic [Width-1:0]   a1,
  input  logic [Width-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*Width-1:0] result,
  output logic               owner,
  output logic               busy
);

  logic [1:0]         state_q;
  logic [1:0]         state_next;
  logic               last_winner_q;
  logic               first_q;
  logic               pick;
  logic               accept;
  logic [Width-1:0]   sel_a;
  logic [Width-1:0]   sel_b;
  logic               mult_busy;
  logic               mult_done;
  logic [2*Width-1:0] mult_product;
  logic [2*Width-1:0] result_q;
  logic               owner_q;

  // Arbitration: a lone requester wins; a tie goes to the one that lost last.
  always_comb begin
    pick = REQ0;
    if (req0 && req1) begin
      pick = ~last_winner_q;
    end else if (req1) begin
      pick = REQ1;
    end
    accept = (state_q == S_IDLE) && (req0 || req1);
    sel_a  = (pick == REQ1) ? a1 : a0;
    sel_b  = (pick == REQ1) ? b1 : b0;
  end

  seq_multiplier #(
    .Width (Width)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .a       (sel_a),
    .b       (sel_b),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // FSM next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = S_IDLE;
    case (state_q)
      S_IDLE: state_next = accept ? S_CALC : S_IDLE;
      S_CALC: begin
        if (mult_done) begin
          state_next = S_DONE;
        end else if (!mult_busy) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_CALC;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Winner history, grant-cycle marker and the published result/owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= REQ1;
      first_q       <= 1'b0;
      result_q      <= '0;
      owner_q       <= REQ0;
    end else begin
      first_q <= accept;
      if (accept) begin
        last_winner_q <= pick;
      end
      if ((state_q == S_CALC) && mult_done) begin
        result_q <= mult_product;
        owner_q  <= last_winner_q;
      end
    end
  end

  // FSM output decode: grant in the first CALC cycle, done in DONE.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = (state_q != S_IDLE);
    case (state_q)
      S_CALC: begin
        gnt0 = first_q && (last_winner_q == REQ0);
        gnt1 = first_q && (last_winner_q == REQ1);
      end
      S_DONE: begin
        done0 = (owner_q == REQ0);
        done1 = (owner_q == REQ1);
      end
      default: ;
    endcase
  end

  assign result = result_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: reset state, round-robin tie handling,
// products at the corners, operand capture at grant and mid-operation abort.
module tb_mul_arbiter;

  localparam int Width = 8;

  logic               clk;
  logic               rst_n;
  logic               req0;
  logic [Width-1:0]   a0;
  logic [Width-1:0]   b0;
  logic               req1;
  logic [Width-1:0]   a1;
  logic [Width-1:0]   b1;
  logic               gnt0;
  logic               gnt1;
  logic               done0;
  logic               done1;
  logic [2*Width-1:0] result;
  logic               owner;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;

  mul_arbiter #(
    .Width (Width)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .owner  (owner),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the grant cycle; follows the operation through DONE and back
  // to IDLE. Optionally re-raises the served requester during DONE.
  task automatic finish_op(input string tag, input logic id, input logic [15:0] exp,
                           input logic rearm);
    for (int i = 0; i < 7; i++) begin
      tick();
      check({tag, " calc done"}, {30'd0, done1, done0}, 32'd0);
      check({tag, " calc gnt"},  {30'd0, gnt1, gnt0}, 32'd0);
      check({tag, " calc busy"}, {31'd0, busy}, 32'd1);
    end
    tick();
    check({tag, " done0"},  {31'd0, done0}, {31'd0, (id == 1'b0)});
    check({tag, " done1"},  {31'd0, done1}, {31'd0, (id == 1'b1)});
    check({tag, " result"}, {16'd0, result}, {16'd0, exp});
    check({tag, " owner"},  {31'd0, owner}, {31'd0, id});
    if (rearm) begin
      if (id) req1 = 1'b1;
      else    req0 = 1'b1;
    end
    tick();
    check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    check({tag, " idle done"}, {30'd0, done1, done0}, 32'd0);
    check({tag, " held result"}, {16'd0, result}, {16'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst outputs", {26'd0, gnt0, gnt1, done0, done1, owner, busy}, 32'd0);
    check("rst result", {16'd0, result}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post-rst busy", {31'd0, busy}, 32'd0);

    // Both requesters held: grants alternate 0,1,0,1.
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd4;
    req1 = 1'b1; a1 = 8'd5; b1 = 8'd6;
    tick();
    check("tie1 gnt", {30'd0, gnt1, gnt0}, 32'b01);
    check("tie1 busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    finish_op("tie1", 1'b0, 16'd12, 1'b1);
    tick();
    check("tie2 gnt", {30'd0, gnt1, gnt0}, 32'b10);
    req1 = 1'b0;
    finish_op("tie2", 1'b1, 16'd30, 1'b1);
    tick();
    check("tie3 gnt", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 1'b0;
    finish_op("tie3", 1'b0, 16'd12, 1'b0);
    tick();
    check("tie4 gnt", {30'd0, gnt1, gnt0}, 32'b10);
    req1 = 1'b0;
    finish_op("tie4", 1'b1, 16'd30, 1'b0);

    // Single requester 0: 12 * 10.
    req0 = 1'b1; a0 = 8'd12; b0 = 8'd10;
    tick();
    check("r0 gnt", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 1'b0;
    finish_op("r0 12x10", 1'b0, 16'd120, 1'b0);

    // Largest operands on requester 1, then a zero multiplicand.
    req1 = 1'b1; a1 = 8'd255; b1 = 8'd255;
    tick();
    check("max gnt", {30'd0, gnt1, gnt0}, 32'b10);
    req1 = 1'b0;
    finish_op("max", 1'b1, 16'hFE01, 1'b0);
    req0 = 1'b1; a0 = 8'd0; b0 = 8'd200;
    tick();
    check("zero gnt", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 1'b0;
    finish_op("zero", 1'b0, 16'd0, 1'b0);

    // Operands changed right after grant must not affect the product.
    req0 = 1'b1; a0 = 8'd13; b0 = 8'd11;
    tick();
    check("latch gnt", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 1'b0; a0 = 8'd200; b0 = 8'd201;
    finish_op("latch", 1'b0, 16'd143, 1'b0);

    // Reset during the fourth CALC cycle aborts the operation.
    req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
    tick();
    check("abort gnt", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 1'b0;
    repeat (3) tick();
    check("abort pre busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort result", {16'd0, result}, 32'd0);
    check("abort outputs", {26'd0, gnt0, gnt1, done0, done1, owner, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort no done", {29'd0, done1, done0, busy}, 32'd0);
    end

    // Normal operation resumes: requester 1, 7 * 9.
    req1 = 1'b1; a1 = 8'd7; b1 = 8'd9;
    tick();
    check("resume gnt", {30'd0, gnt1, gnt0}, 32'b10);
    req1 = 1'b0;
    finish_op("resume", 1'b1, 16'd63, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
